// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - AUTO/MANUAL lamp mode controller driven by long (A) / short (B) press events.
// Optional MANUAL_TIMEOUT_EN: MANUAL reverts to AUTO after MANUAL_TIMEOUT idle cycles.
module mode_controller #(
  parameter int OFF_DELAY      = 30000,
  parameter int MANUAL_TIMEOUT = 60000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic presence,
  output logic lamp,
  output logic mode
);

  localparam int LP_CNT_MAX = (OFF_DELAY > MANUAL_TIMEOUT) ? OFF_DELAY : MANUAL_TIMEOUT;

  if (longint'(LP_CNT_MAX) > (longint'(1) << CNT_W)) begin : g_cnt_too_narrow
    $error("mode_controller: CNT_W too narrow for OFF_DELAY/MANUAL_TIMEOUT");
  end

  typedef enum logic [2:0] {
    AUTO_OFF  = 3'd0,
    AUTO_ON   = 3'd1,
    AUTO_HOLD = 3'd2,
    MAN_OFF   = 3'd3,
    MAN_ON    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_man_exit;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_a_q;
  logic             r_b_q;
  logic             r_lamp;
  logic             r_mode;
  logic             w_ev_a;
  logic             w_ev_b;
  logic             w_hold_done;
  logic             w_man_done;

  assign w_ev_a      = A & ~r_a_q;
  assign w_ev_b      = B & ~r_b_q;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_hold_done = (r_cnt == CNT_W'(OFF_DELAY - 1));
  assign w_man_exit  = presence ? AUTO_ON : AUTO_OFF;

`ifdef MANUAL_TIMEOUT_EN
  assign w_man_done  = (r_cnt == CNT_W'(MANUAL_TIMEOUT - 1));
`else
  assign w_man_done  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      AUTO_OFF: begin
        if (w_ev_a) begin
          w_state_nxt = MAN_OFF;
          w_cnt_nxt   = '0;
        end else if (presence) begin
          w_state_nxt = AUTO_ON;
        end
      end
      AUTO_ON: begin
        if (w_ev_a) begin
          w_state_nxt = MAN_OFF;
          w_cnt_nxt   = '0;
        end else if (!presence) begin
          w_state_nxt = AUTO_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      AUTO_HOLD: begin
        if (w_ev_a) begin
          w_state_nxt = MAN_OFF;
          w_cnt_nxt   = '0;
        end else if (presence) begin
          w_state_nxt = AUTO_ON;
        end else if (w_hold_done) begin
          w_state_nxt = AUTO_OFF;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      MAN_OFF, MAN_ON: begin
        // A long press (or the idle timeout) leaves MANUAL; any B in that cycle is dropped
        if (w_ev_a || w_man_done) begin
          w_state_nxt = w_man_exit;
          w_cnt_nxt   = '0;
        end else if (w_ev_b) begin
          w_state_nxt = (r_state == MAN_OFF) ? MAN_ON : MAN_OFF;
          w_cnt_nxt   = '0;
        end else begin
`ifdef MANUAL_TIMEOUT_EN
          w_cnt_nxt   = w_cnt_inc;
`else
          w_cnt_nxt   = r_cnt;
`endif
        end
      end
      default: begin
        w_state_nxt = AUTO_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= AUTO_OFF;
      r_cnt   <= '0;
      r_a_q   <= 1'b0;
      r_b_q   <= 1'b0;
      r_lamp  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a_q   <= A;
      r_b_q   <= B;
      // Outputs decode the current state, so they trail the state change by one cycle
      r_lamp  <= (r_state == AUTO_ON) || (r_state == AUTO_HOLD) || (r_state == MAN_ON);
      r_mode  <= (r_state == MAN_OFF) || (r_state == MAN_ON);
    end
  end

  assign lamp = r_lamp;
  assign mode = r_mode;

endmodule
